csr_unit: RTL and testbench
===========================

Name: csr_unit

Overview:
- Initiator side of the core's CSR access interface. Executes Zicsr instructions (CSRRW/RS/RC and immediate forms) as a read-modify-write sequence against the CSR file over its wen/addr/wdata/rdata port.
- Sits between decode/execute and the CSR file. Returns the old CSR value for rd, or flags an illegal access.
- Uses one request/response handshake on the core side and a fixed three-state access sequence on the CSR side.

Parameters:
- XLEN, 32, data width of CSR values and rs1.
- AW, 12, CSR address width.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  instruction request valid
- req_ready  out  1  unit can accept a request
- req_funct3  in  3  Zicsr funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_addr  in  AW  CSR address (instr[31:20])
- req_rs1  in  XLEN  rs1 register value
- req_src_idx  in  5  rs1 index, or uimm for the immediate forms (instr[19:15])
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  XLEN  old CSR value, for rd
- resp_illegal  out  1  access is illegal; rd write and trap decided by the consumer
- csr_wen  out  1  CSR file write enable
- csr_addr  out  AW  CSR file address
- csr_wdata  out  XLEN  CSR file write data
- csr_rdata  in  XLEN  CSR file combinational read data

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_illegal=0; csr_wen=0; csr_addr=0; csr_wdata=0.
- **States:** IDLE, READ, WRITE, RESP.
- **IDLE:**
  - req_ready=1.
  - On req_valid, latch funct3, addr, src operand and src_idx, then go to READ.
  - src operand = req_rs1 for funct3[2]=0; zero-extended req_src_idx for funct3[2]=1.
- **READ:**
  - Drive csr_addr=latched addr, csr_wen=0. Capture csr_rdata into old.
  - Decide the write:
    - do_write=1 for RW/RWI.
    - For RS/RC/RSI/RCI, do_write = (src_idx != 0).
  - Decide illegal:
    - funct3 ∈ {000,100}, or
    - do_write and addr[11:10]==2'b11 (read-only space, e.g. 0xF11/0xF12).
  - If illegal or !do_write, go to RESP. Otherwise go to WRITE.
- **WRITE:**
  - csr_wen=1 for exactly one cycle; csr_addr=latched addr.
  - csr_wdata: RW = src; RS = old | src; RC = old & ~src.
  - Next state is RESP.
- **RESP:**
  - resp_valid=1; resp_rdata=old, or 0 if illegal; resp_illegal as decided.
  - Hold all outputs stable until resp_ready. On resp_valid & resp_ready, go to IDLE.
- **Latency and throughput:**
  - Write access: 3 cycles from accept to resp_valid.
  - Read-only access: 2 cycles.
  - No overlap; req_ready=0 outside IDLE.
- csr_wen is 0 in all states except WRITE. csr_addr holds its last value in IDLE.
- **Free-running counters:** the CSR file advances mcycle by one between READ and WRITE. An RS/RC to 0xB00/0xB80 therefore writes old-derived data, which intentionally discards that one increment. The write value always wins over the increment.
- **Unimplemented addresses:** the CSR file returns 0 and the access is legal. This unit does not trap on them.
- **Reset mid-operation:** return immediately to IDLE with reset values. No partial write is issued after reset deasserts.
- **Response backpressure:** resp_ready low for N cycles keeps RESP; no further CSR-side activity occurs.

Decomposition:
- Package csr_pkg holds:
  - funct3 encodings (CSR_RW..CSR_RCI);
  - CSR address constants (CYCLE 0xB00, CYCLEH 0xB80, MVENDORID 0xF11, MARCHID 0xF12);
  - the state enum typedef.
- Optional combinational sub-module csr_alu computes wdata from (funct3[1:0], old, src).

Test Plan:
- CSRRW 0xB00, rs1=0x0000_0100: exactly one csr_wen pulse with addr 0xB00 and wdata 0x100. resp_rdata = pre-write low cycle count. A following CSRRS x0 read returns ≥0x100 and <0x110.
- CSRRS 0xF12, src_idx=0: no csr_wen. resp_rdata=0x05318008, resp_illegal=0, resp_valid 2 cycles after accept.
- CSRRW 0xF11, rs1=0x1: no csr_wen, resp_illegal=1, resp_rdata=0. A subsequent read of 0xF11 still returns 0x616b6562.
- CSRRCI 0xB80, uimm=0x3, after a CSRRW to 0xB80 of 0xF: wdata=0xC, resp_rdata=0xF.
- resp_ready held low for 5 cycles in RESP: resp_valid/resp_rdata stay stable, req_ready=0, csr_wen=0 throughout. Back in IDLE one cycle after the handshake.
- Reset asserted in the WRITE cycle of CSRRW 0xB00: outputs return to reset values asynchronously, and no csr_wen occurs after reset release. funct3=000 request → resp_illegal=1 with no write.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: Zicsr funct3 codes,
// read-modify-write operation codes, well-known CSR addresses and the
// access sequencer state type.
package csr_pkg;

  // Zicsr funct3 encodings (bit 2 selects the immediate form)
  localparam logic [2:0] CSR_RW  = 3'b001;
  localparam logic [2:0] CSR_RS  = 3'b010;
  localparam logic [2:0] CSR_RC  = 3'b011;
  localparam logic [2:0] CSR_RWI = 3'b101;
  localparam logic [2:0] CSR_RSI = 3'b110;
  localparam logic [2:0] CSR_RCI = 3'b111;

  // Low two funct3 bits select the read-modify-write operation
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  // CSR addresses the unit and its neighbours care about
  localparam logic [11:0] CSR_CYCLE     = 12'hB00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hB80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  // Access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/csr_alu.sv
// Combinational write-data generator for the read-modify-write sequence:
// plain write, bit set or bit clear of the old CSR value.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] src,
  output logic [XLEN-1:0] wdata
);

  // Select the new CSR value from the old value and the source operand
  always_comb begin
    wdata = '0;
    case (op)
      OP_RW:   wdata = src;
      OP_RS:   wdata = old | src;
      OP_RC:   wdata = old & ~src;
      default: wdata = '0;
    endcase
  end

endmodule

// File: rtl/csr_unit.sv
// Initiator side of the CSR access port. Accepts one Zicsr instruction at a
// time, reads the CSR, optionally writes the modified value back, and returns
// the old value (or an illegal-access flag) to the consumer.
module csr_unit
  import csr_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [AW-1:0]   req_addr,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [4:0]      req_src_idx,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_illegal,
  output logic            csr_wen,
  output logic [AW-1:0]   csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata
);

  state_t          state;
  state_t          next_state;

  logic [1:0]      op_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] src_q;
  logic [4:0]      src_idx_q;
  logic [XLEN-1:0] old_q;
  logic            illegal_q;

  logic            do_write;
  logic            illegal;
  logic [XLEN-1:0] alu_wdata;
  logic [XLEN-1:0] src_sel;

  // Immediate forms use the rs1 field itself as a zero-extended operand
  assign src_sel = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_src_idx} : req_rs1;

  // Set/clear with a zero source (x0 or uimm 0) must not write, so that
  // read-only CSRs can be read with CSRRS/CSRRC without trapping
  assign do_write = (op_q == OP_RW) || (src_idx_q != 5'd0);
  assign illegal  = (op_q == OP_NONE) ||
                    (do_write && (addr_q[AW-1:AW-2] == 2'b11));

  // The address tracks the latched request so it holds its last value in IDLE
  assign csr_addr = addr_q;

  csr_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op   (op_q),
    .old  (old_q),
    .src  (src_q),
    .wdata(alu_wdata)
  );

  // State register; reset abandons any in-flight access immediately
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the request on accept and capture the old value and legality in READ
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q      <= OP_NONE;
      addr_q    <= '0;
      src_q     <= '0;
      src_idx_q <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_funct3[1:0];
            addr_q    <= req_addr;
            src_q     <= src_sel;
            src_idx_q <= req_src_idx;
          end
        end
        ST_READ: begin
          old_q     <= csr_rdata;
          illegal_q <= illegal;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state and output decode; all outputs are pure functions of registers
  always_comb begin
    next_state   = state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_illegal = 1'b0;
    csr_wen      = 1'b0;
    csr_wdata    = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = ST_READ;
        end
      end
      ST_READ: begin
        if (illegal || !do_write) begin
          next_state = ST_RESP;
        end else begin
          next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        csr_wen    = 1'b1;
        csr_wdata  = alu_wdata;
        next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid   = 1'b1;
        resp_illegal = illegal_q;
        resp_rdata   = illegal_q ? '0 : old_q;
        if (resp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: a small behavioural CSR file with a
// free-running cycle counter, a vector table, hand-written counter /
// backpressure / reset sequences, and a randomized run against a model.
module tb_csr_unit;
  import csr_pkg::*;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1;
  logic [4:0]  req_src_idx;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_illegal;
  logic        csr_wen;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  int num_compared;
  int num_failed;

  csr_unit #(
    .XLEN(32),
    .AW  (12)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_rs1     (req_rs1),
    .req_src_idx (req_src_idx),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_illegal(resp_illegal),
    .csr_wen     (csr_wen),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata)
  );

  // Free-running core clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural CSR file: mcycle, three scratch-like registers, ID registers
  logic [63:0] mcycle;
  logic [31:0] mscratch, mepc, mtvec, mvendorid, marchid;

  // Combinational read port of the CSR file
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_CYCLE:     csr_rdata = mcycle[31:0];
      CSR_CYCLEH:    csr_rdata = mcycle[63:32];
      12'h340:       csr_rdata = mscratch;
      12'h341:       csr_rdata = mepc;
      12'h305:       csr_rdata = mtvec;
      CSR_MVENDORID: csr_rdata = mvendorid;
      CSR_MARCHID:   csr_rdata = marchid;
      default:       csr_rdata = '0;
    endcase
  end

  // Counter increments every cycle; a write to a counter half wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcycle    <= '0;
      mscratch  <= '0;
      mepc      <= '0;
      mtvec     <= '0;
      mvendorid <= 32'h616b6562;
      marchid   <= 32'h05318008;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (csr_wen) begin
        case (csr_addr)
          CSR_CYCLE:     mcycle[31:0]  <= csr_wdata;
          CSR_CYCLEH:    mcycle[63:32] <= csr_wdata;
          12'h340:       mscratch      <= csr_wdata;
          12'h341:       mepc          <= csr_wdata;
          12'h305:       mtvec         <= csr_wdata;
          CSR_MVENDORID: mvendorid     <= csr_wdata;
          CSR_MARCHID:   marchid       <= csr_wdata;
          default: begin
          end
        endcase
      end
    end
  end

  // Write-pulse monitor, sampled mid-cycle
  int          wen_count = 0;
  logic [11:0] wen_addr  = '0;
  logic [31:0] wen_data  = '0;
  always @(negedge clock) begin
    if (csr_wen === 1'b1) begin
      wen_count <= wen_count + 1;
      wen_addr  <= csr_addr;
      wen_data  <= csr_wdata;
    end
  end

  // Results of the last transaction
  logic [31:0] got_rdata;
  logic        got_illegal;
  logic        got_ready;
  logic        got_stable;
  logic        got_idle;
  int          got_latency;
  int          got_wens;
  logic [31:0] pre_cycle;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic doReset();
    req_valid   = 1'b0;
    resp_ready  = 1'b0;
    req_funct3  = '0;
    req_addr    = '0;
    req_rs1     = '0;
    req_src_idx = '0;
    reset       = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Issue one request, wait (bounded) for the response, optionally hold
  // resp_ready low for 'hold' cycles, then complete the handshake
  task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] a,
                               input logic [31:0] rs1, input logic [4:0] idx,
                               input int hold);
    int  start_wen;
    bit  seen;
    @(negedge clock);
    req_funct3  = f3;
    req_addr    = a;
    req_rs1     = rs1;
    req_src_idx = idx;
    req_valid   = 1'b1;
    #1;
    got_ready = req_ready;
    start_wen = wen_count;
    pre_cycle = mcycle[31:0];
    @(posedge clock);
    #1;
    req_valid   = 1'b0;
    req_rs1     = $urandom;
    req_src_idx = 5'($urandom);
    req_addr    = 12'($urandom);
    req_funct3  = 3'($urandom);
    got_latency = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      got_latency++;
      if (resp_valid === 1'b1) seen = 1;
    end
    if (!seen) got_latency = -1;
    got_rdata   = resp_rdata;
    got_illegal = resp_illegal;
    got_stable  = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_rdata !== got_rdata || resp_illegal !== got_illegal ||
          req_ready !== 1'b0 || csr_wen !== 1'b0)
        got_stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    got_idle = (req_ready === 1'b1) && (resp_valid === 1'b0);
    got_wens = wen_count - start_wen;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  idx;
    logic [31:0] exp_rdata;
    logic        exp_ill;
    int          exp_wens;
    logic [31:0] exp_wdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  // Reference model of the CSR contents for the randomized run
  logic [31:0] mdl[logic [11:0]];

  function automatic logic [31:0] mdlRead(input logic [11:0] a);
    return mdl.exists(a) ? mdl[a] : 32'h0;
  endfunction

  initial begin
    logic [11:0] addr_list[7];
    num_compared = 0;
    num_failed   = 0;

    // ---------------- reset state ----------------
    req_valid = 1'b0; resp_ready = 1'b0; reset = 1'b1;
    req_funct3 = '0; req_addr = '0; req_rs1 = '0; req_src_idx = '0;
    #12;
    checkOutput("reset req_ready", req_ready, 1);
    checkOutput("reset resp_valid", resp_valid, 0);
    checkOutput("reset resp_rdata", resp_rdata, 0);
    checkOutput("reset resp_illegal", resp_illegal, 0);
    checkOutput("reset csr_wen", csr_wen, 0);
    checkOutput("reset csr_addr", csr_addr, 0);
    checkOutput("reset csr_wdata", csr_wdata, 0);
    doReset();

    // ---------------- vector table ----------------
    vecs.push_back('{CSR_RW,  12'h340, 32'hDEADBEEF, 5'd5,  32'h0,        1'b0, 1, 32'hDEADBEEF, 3});
    vecs.push_back('{CSR_RS,  12'h340, 32'h000000F0, 5'd6,  32'hDEADBEEF, 1'b0, 1, 32'hDEADBEFF, 3});
    vecs.push_back('{CSR_RC,  12'h340, 32'hFFFF0000, 5'd7,  32'hDEADBEFF, 1'b0, 1, 32'h0000BEFF, 3});
    vecs.push_back('{CSR_RS,  12'h340, 32'hFFFFFFFF, 5'd0,  32'h0000BEFF, 1'b0, 0, 32'h0,        2});
    vecs.push_back('{CSR_RWI, 12'h341, 32'h12345678, 5'h1F, 32'h0,        1'b0, 1, 32'h1F,       3});
    vecs.push_back('{CSR_RSI, 12'h341, 32'h0,        5'h0A, 32'h1F,       1'b0, 1, 32'h1F,       3});
    vecs.push_back('{CSR_RCI, 12'h341, 32'hFFFFFFFF, 5'h03, 32'h1F,       1'b0, 1, 32'h1C,       3});
    vecs.push_back('{CSR_RCI, 12'h341, 32'h0,        5'h00, 32'h1C,       1'b0, 0, 32'h0,        2});
    vecs.push_back('{CSR_RW,  12'h305, 32'h80000000, 5'd9,  32'h0,        1'b0, 1, 32'h80000000, 3});
    vecs.push_back('{CSR_RW,  12'h305, 32'h0,        5'd0,  32'h80000000, 1'b0, 1, 32'h0,        3});
    vecs.push_back('{CSR_RS,  12'hF12, 32'h0,        5'd0,  32'h05318008, 1'b0, 0, 32'h0,        2});
    vecs.push_back('{CSR_RW,  12'hF11, 32'h1,        5'd1,  32'h0,        1'b1, 0, 32'h0,        2});
    vecs.push_back('{CSR_RS,  12'hF11, 32'h0,        5'd0,  32'h616b6562, 1'b0, 0, 32'h0,        2});
    vecs.push_back('{3'b000,  12'h340, 32'hFFFFFFFF, 5'd1,  32'h0,        1'b1, 0, 32'h0,        2});
    vecs.push_back('{3'b100,  12'h341, 32'h0,        5'd3,  32'h0,        1'b1, 0, 32'h0,        2});
    vecs.push_back('{CSR_RW,  12'h7C0, 32'hAA,       5'd2,  32'h0,        1'b0, 1, 32'hAA,       3});
    vecs.push_back('{CSR_RSI, 12'hC00, 32'h0,        5'd0,  32'h0,        1'b0, 0, 32'h0,        2});
    vecs.push_back('{CSR_RSI, 12'hC00, 32'h0,        5'd1,  32'h0,        1'b1, 0, 32'h0,        2});
    vecs.push_back('{CSR_RWI, 12'hF12, 32'h0,        5'd0,  32'h0,        1'b1, 0, 32'h0,        2});
    vecs.push_back('{CSR_RS,  12'h305, 32'h0,        5'd0,  32'h0,        1'b0, 0, 32'h0,        2});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].idx, 0);
      checkOutput($sformatf("v%0d req_ready", i), got_ready, 1);
      checkOutput($sformatf("v%0d rdata", i), got_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d illegal", i), got_illegal, vecs[i].exp_ill);
      checkOutput($sformatf("v%0d wen pulses", i), got_wens, vecs[i].exp_wens);
      checkOutput($sformatf("v%0d latency", i), got_latency, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d idle after", i), got_idle, 1);
      if (vecs[i].exp_wens != 0) begin
        checkOutput($sformatf("v%0d wen addr", i), wen_addr, vecs[i].addr);
        checkOutput($sformatf("v%0d wdata", i), wen_data, vecs[i].exp_wdata);
      end
    end

    // ---------------- cycle counter sequences ----------------
    applyStimulus(CSR_RW, CSR_CYCLE, 32'h100, 5'd1, 0);
    checkOutput("cycle rw wen pulses", got_wens, 1);
    checkOutput("cycle rw wen addr", wen_addr, CSR_CYCLE);
    checkOutput("cycle rw wdata", wen_data, 32'h100);
    checkOutput("cycle rw rdata", got_rdata, pre_cycle + 32'd1);
    applyStimulus(CSR_RS, CSR_CYCLE, 32'h0, 5'd0, 0);
    num_compared++;
    if (got_rdata < 32'h100 || got_rdata >= 32'h110) begin
      num_failed++;
      $display("[TB] FAIL cycle readback: got 0x%0h expected range 0x100..0x10f", got_rdata);
    end
    checkOutput("cycle readback wen pulses", got_wens, 0);

    applyStimulus(CSR_RW, CSR_CYCLEH, 32'hF, 5'd4, 0);
    checkOutput("cycleh rw wdata", wen_data, 32'hF);
    applyStimulus(CSR_RCI, CSR_CYCLEH, 32'h0, 5'd3, 0);
    checkOutput("cycleh rci wen pulses", got_wens, 1);
    checkOutput("cycleh rci wdata", wen_data, 32'hC);
    checkOutput("cycleh rci rdata", got_rdata, 32'hF);

    // ---------------- response backpressure ----------------
    applyStimulus(CSR_RS, 12'h340, 32'h0, 5'd0, 5);
    checkOutput("backpressure rdata", got_rdata, 32'h0000BEFF);
    checkOutput("backpressure stable", got_stable, 1);
    checkOutput("backpressure idle after", got_idle, 1);
    checkOutput("backpressure wen pulses", got_wens, 0);

    // ---------------- reset during WRITE ----------------
    begin
      int start_wen;
      @(negedge clock);
      req_funct3 = CSR_RW; req_addr = CSR_CYCLE; req_rs1 = 32'h100; req_src_idx = 5'd1;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkOutput("rst in write csr_wen", csr_wen, 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("rst async req_ready", req_ready, 1);
      checkOutput("rst async resp_valid", resp_valid, 0);
      checkOutput("rst async csr_wen", csr_wen, 0);
      checkOutput("rst async csr_addr", csr_addr, 0);
      checkOutput("rst async csr_wdata", csr_wdata, 0);
      checkOutput("rst async resp_rdata", resp_rdata, 0);
      start_wen = wen_count;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (8) @(negedge clock);
      checkOutput("rst no late wen", wen_count - start_wen, 0);
      checkOutput("rst idle after", req_ready, 1);
    end
    applyStimulus(3'b000, CSR_CYCLE, 32'h5, 5'd2, 0);
    checkOutput("post-rst f3=000 illegal", got_illegal, 1);
    checkOutput("post-rst f3=000 wen pulses", got_wens, 0);

    // ---------------- randomized run against the model ----------------
    doReset();
    mdl.delete();
    mdl[12'h340] = 32'h0;
    mdl[12'h341] = 32'h0;
    mdl[12'h305] = 32'h0;
    mdl[CSR_MVENDORID] = 32'h616b6562;
    mdl[CSR_MARCHID]   = 32'h05318008;
    addr_list[0] = 12'h340; addr_list[1] = 12'h341; addr_list[2] = 12'h305;
    addr_list[3] = CSR_MVENDORID; addr_list[4] = CSR_MARCHID;
    addr_list[5] = 12'h7C0; addr_list[6] = 12'hC00;
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [11:0] a;
      logic [31:0] rs1, src, old, nv;
      logic [4:0]  idx;
      logic        wr, ill;
      int          hold;
      f3   = 3'($urandom_range(0, 7));
      a    = addr_list[$urandom_range(0, 6)];
      rs1  = $urandom;
      idx  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      hold = $urandom_range(0, 2);
      src  = f3[2] ? {27'd0, idx} : rs1;
      wr   = (f3 == CSR_RW || f3 == CSR_RWI) || (idx != 0);
      ill  = (f3 == 3'b000 || f3 == 3'b100) || (wr && a >= 12'hC00);
      old  = mdlRead(a);
      if (f3 == CSR_RW || f3 == CSR_RWI)      nv = src;
      else if (f3 == CSR_RS || f3 == CSR_RSI) nv = old | src;
      else                                    nv = old & ~src;
      applyStimulus(f3, a, rs1, idx, hold);
      checkOutput($sformatf("rnd%0d rdata", n), got_rdata, ill ? 32'h0 : old);
      checkOutput($sformatf("rnd%0d illegal", n), got_illegal, ill);
      checkOutput($sformatf("rnd%0d wen pulses", n), got_wens, (!ill && wr) ? 1 : 0);
      checkOutput($sformatf("rnd%0d latency", n), got_latency, (!ill && wr) ? 3 : 2);
      checkOutput($sformatf("rnd%0d stable", n), got_stable, 1);
      if (!ill && wr) begin
        checkOutput($sformatf("rnd%0d wdata", n), wen_data, nv);
        if (mdl.exists(a)) mdl[a] = nv;
      end
    end
    checkOutput("final mscratch", mscratch, mdl[12'h340]);
    checkOutput("final mepc", mepc, mdl[12'h341]);
    checkOutput("final mtvec", mtvec, mdl[12'h305]);
    checkOutput("final mvendorid", mvendorid, 32'h616b6562);
    checkOutput("final marchid", marchid, 32'h05318008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_failed);
    $finish;
  end

endmodule
